// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the M-stage store write buffer: store op encodings,
// byte-enable constants and the buffered entry layout.
package store_write_buffer_pkg;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } st_op_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // One formatted store as presented to data memory.
  typedef struct packed {
    logic [31:0] addr;    // word-aligned address
    logic [31:0] wdata;   // lane-replicated data
    logic [3:0]  byteen;  // bit i enables byte i
    logic [31:0] pc;      // PC of the store
  } sb_entry_t;

endpackage

// File: rtl/store_lane_format.sv
// Combinational store formatter: narrows register data to word/half/byte,
// replicates it across the lanes and forms the byte enables.
// Ports:
//   op_i         store op (SW/SH/SB/reserved)
//   addr_lo_i    byte offset within the word (addr[1:0])
//   data_i       rt register value
//   wdata_o      lane-replicated write data
//   byteen_o     byte enables, bit i = byte i
//   misaligned_o offset not allowed for op, or reserved op
module store_lane_format
  import store_write_buffer_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  byteen_o,
  output logic        misaligned_o
);

  always_comb begin
    wdata_o      = data_i;
    byteen_o     = BE_NONE;
    misaligned_o = 1'b0;
    case (st_op_e'(op_i))
      OP_SW: begin
        wdata_o      = data_i;
        byteen_o     = BE_WORD;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      OP_SH: begin
        wdata_o      = {2{data_i[15:0]}};
        byteen_o     = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        misaligned_o = addr_lo_i[0];
      end
      OP_SB: begin
        wdata_o      = {4{data_i[7:0]}};
        byteen_o     = BE_BYTE0 << addr_lo_i;
        misaligned_o = 1'b0;
      end
      default: begin
        // Reserved op is reported through the same error path as misalignment.
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// M-stage store write buffer: formats stores, queues them in a DEPTH-entry
// FIFO draining to data memory over valid/ready, and reports misaligned or
// reserved stores with a one-cycle error pulse instead of buffering them.
// Ports:
//   clk, reset               clock / asynchronous active-high reset
//   in_valid/in_ready        store request handshake (in_ready is the stall source)
//   in_op/in_addr/in_data/in_pc  store request payload
//   m_valid/m_ready          head entry handshake to memory
//   m_addr/m_wdata/m_byteen/m_pc  head entry payload (zero when no entry)
//   err_valid/err_addr/err_pc     misalignment pulse and offending store
//   empty                    no entry pending
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [31:0] in_pc,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_pc,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic [31:0] err_pc,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  sb_entry_t         mem_q [DEPTH];
  sb_entry_t         head;
  sb_entry_t         new_entry;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q;
  logic              err_valid_q, err_valid_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [31:0]       err_pc_q, err_pc_d;

  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_byteen;
  logic              fmt_mis;
  logic              accept, push, pop;

  store_lane_format u_fmt (
    .op_i         (in_op),
    .addr_lo_i    (in_addr[1:0]),
    .data_i       (in_data),
    .wdata_o      (fmt_wdata),
    .byteen_o     (fmt_byteen),
    .misaligned_o (fmt_mis)
  );

  // Handshakes: full blocks input even if the head pops this cycle.
  assign in_ready = (count_q < CW'(DEPTH));
  assign m_valid  = (count_q != '0);
  assign accept   = in_valid & in_ready;
  assign push     = accept & ~fmt_mis;
  assign pop      = m_valid & m_ready;

  assign new_entry.addr   = {in_addr[31:2], 2'b00};
  assign new_entry.wdata  = fmt_wdata;
  assign new_entry.byteen = fmt_byteen;
  assign new_entry.pc     = in_pc;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_valid_d = accept & fmt_mis;
    err_addr_d  = err_addr_q;
    err_pc_d    = err_pc_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept & fmt_mis) begin
      err_addr_d = in_addr;
      err_pc_d   = in_pc;
    end
  end

  // Control and error state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_pc_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_pc_q    <= err_pc_d;
    end
  end

  // FIFO storage carries no reset; outputs are masked by m_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head     = mem_q[rd_ptr_q];
  assign m_addr   = m_valid ? head.addr   : 32'h0;
  assign m_wdata  = m_valid ? head.wdata  : 32'h0;
  assign m_byteen = m_valid ? head.byteen : 4'h0;
  assign m_pc     = m_valid ? head.pc     : 32'h0;

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_pc    = err_pc_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_addr, in_data, in_pc;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata, m_pc;
  logic [3:0]  m_byteen;
  logic        err_valid;
  logic [31:0] err_addr, err_pc;
  logic        empty;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_byteen  (m_byteen),
    .m_pc      (m_pc),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_pc    (err_pc),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          err;
    logic [31:0] ea;   // expected m_addr
    logic [31:0] wd;   // expected m_wdata
    logic [3:0]  be;   // expected m_byteen
  } vec_t;

  vec_t        tbl [12];
  vec_t        q [$];
  vec_t        cur;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          last_acc;
  logic [31:0] last_err_addr, last_err_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] pc, input bit err, input logic [31:0] ea,
                              input logic [31:0] wd, input logic [3:0] be);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.pc = pc;
    v.err = err; v.ea = ea; v.wd = wd; v.be = be;
    return v;
  endfunction

  function automatic vec_t mk_sw(input int k);
    return mk(2'b00, 32'h3000 + 32'(4 * k), 32'h0100 + 32'(k), 32'h8000 + 32'(4 * k), 1'b0,
              32'h3000 + 32'(4 * k), 32'h0100 + 32'(k), 4'b1111);
  endfunction

  // One clock: check outputs against the reference queue, then advance.
  task automatic cycle();
    bit pop, acc;
    in_op = cur.op; in_addr = cur.addr; in_data = cur.data; in_pc = cur.pc;
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    if (q.size() != 0) begin
      chk("m_addr", m_addr, q[0].ea);
      chk("m_wdata", m_wdata, q[0].wd);
      chk("m_byteen", 32'(m_byteen), 32'(q[0].be));
      chk("m_pc", m_pc, q[0].pc);
    end else begin
      chk("m_addr_idle", m_addr, 32'h0);
    end
    pop = (q.size() != 0) && m_ready;
    acc = in_valid && (q.size() < DEPTH);
    @(posedge clk);
    @(negedge clk);
    if (pop) void'(q.pop_front());
    if (acc && !cur.err) q.push_back(cur);
    chk("err_valid", 32'(err_valid), 32'(acc && cur.err));
    if (acc && cur.err) begin
      last_err_addr = cur.addr;
      last_err_pc   = cur.pc;
    end
    chk("err_addr", err_addr, last_err_addr);
    chk("err_pc", err_pc, last_err_pc);
    last_acc = acc;
  endtask

  task automatic push_vec(input vec_t v);
    int n;
    n = 0;
    cur = v;
    in_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    chk("accept_timeout", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(2'b00, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0040_0000, 0, 32'h1004, 32'hDEADBEEF, 4'b1111);
    tbl[1]  = mk(2'b01, 32'h0000_1002, 32'h1234_ABCD, 32'h0040_0004, 0, 32'h1000, 32'hABCDABCD, 4'b1100);
    tbl[2]  = mk(2'b10, 32'h0000_1003, 32'h0000_00EF, 32'h0040_0008, 0, 32'h1000, 32'hEFEFEFEF, 4'b1000);
    tbl[3]  = mk(2'b01, 32'h0000_1000, 32'hCAFE_5678, 32'h0040_000C, 0, 32'h1000, 32'h56785678, 4'b0011);
    tbl[4]  = mk(2'b10, 32'h0000_2000, 32'h1122_3344, 32'h0040_0010, 0, 32'h2000, 32'h44444444, 4'b0001);
    tbl[5]  = mk(2'b10, 32'h0000_2001, 32'h0000_00A5, 32'h0040_0014, 0, 32'h2000, 32'hA5A5A5A5, 4'b0010);
    tbl[6]  = mk(2'b10, 32'h0000_2002, 32'hFFFF_FF5A, 32'h0040_0018, 0, 32'h2000, 32'h5A5A5A5A, 4'b0100);
    tbl[7]  = mk(2'b01, 32'h0000_1001, 32'h1111_2222, 32'h0040_001C, 1, 32'h0, 32'h0, 4'h0);
    tbl[8]  = mk(2'b00, 32'h0000_1002, 32'h3333_4444, 32'h0040_0020, 1, 32'h0, 32'h0, 4'h0);
    tbl[9]  = mk(2'b11, 32'h0000_1000, 32'h5555_6666, 32'h0040_0024, 1, 32'h0, 32'h0, 4'h0);
    tbl[10] = mk(2'b00, 32'h0000_1003, 32'h7777_8888, 32'h0040_0028, 1, 32'h0, 32'h0, 4'h0);
    tbl[11] = mk(2'b01, 32'h0000_1003, 32'h9999_AAAA, 32'h0040_002C, 1, 32'h0, 32'h0, 4'h0);

    reset = 1'b1; in_valid = 1'b0; m_ready = 1'b1;
    cur = mk(2'b00, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    in_op = 2'b00; in_addr = '0; in_data = '0; in_pc = '0;
    last_err_addr = '0; last_err_pc = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    reset = 1'b0;

    // Single stores and error cases, one at a time with memory always ready.
    for (int i = 0; i < 12; i++) begin
      push_vec(tbl[i]);
      cycle();
      cycle();
    end

    // Back-pressure: third store held while full, then drained in order.
    m_ready = 1'b0;
    push_vec(mk_sw(1));
    push_vec(mk_sw(2));
    cur = mk_sw(3);
    in_valid = 1'b1;
    cycle();
    cycle();
    chk("third_held", 32'(last_acc), 32'd0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    m_ready = 1'b1;
    push_vec(mk_sw(3));
    drain();

    // Sustained push+pop across pointer wrap.
    m_ready = 1'b0;
    push_vec(mk_sw(10));
    push_vec(mk_sw(11));
    m_ready = 1'b1;
    begin
      int k;
      k = 12;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        cur = mk_sw(k);
        cycle();
        if (last_acc) k++;
      end
      chk("stream_accepts", 32'(k), 32'd21);
    end
    drain();

    // Reset with two entries pending and memory stalled.
    m_ready = 1'b0;
    push_vec(mk_sw(30));
    push_vec(mk_sw(31));
    cur = mk(2'b00, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_m_addr", m_addr, 32'h0);
    chk("mid_rst_err_addr", err_addr, 32'h0);
    q.delete();
    last_err_addr = '0; last_err_pc = '0;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    cycle();
    cycle();
    push_vec(tbl[0]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
